// File: rtl/riscmacro_pkg.sv
// Shared types and constants for the riscmacro memory path: arbiter state
// encoding, requester IDs and the legal range of the memory read latency.
package riscmacro_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t REQ_CPU = 1'b0;
  localparam req_id_t REQ_EXT = 1'b1;

  // Memory read latency (cycles after the access cycle) is legal in 0..3.
  localparam int MEM_LAT_MIN = 0;
  localparam int MEM_LAT_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, external port and cache memory port around
// mem_port_arbiter. The slave modport is the arbiter's view; the master
// modport is the view of the surrounding requesters and memory.
interface mem_port_arbiter_if #(
  parameter int BIT_WIDTH = 32
);

  logic                 cpu_req;
  logic                 cpu_we;
  logic [BIT_WIDTH-1:0] cpu_addr;
  logic [BIT_WIDTH-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;
  logic [BIT_WIDTH-1:0] cpu_rdata;

  logic                 ext_req;
  logic                 ext_we;
  logic [BIT_WIDTH-1:0] ext_addr;
  logic [BIT_WIDTH-1:0] ext_wdata;
  logic                 ext_gnt;
  logic                 ext_rvalid;
  logic [BIT_WIDTH-1:0] ext_rdata;

  logic                 mem_we;
  logic [BIT_WIDTH-1:0] mem_addr;
  logic [BIT_WIDTH-1:0] mem_wdata;
  logic [BIT_WIDTH-1:0] mem_rdata;

  logic                 busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Starvation guard for mem_port_arbiter: counts external grants made while
// the CPU is waiting and forces a CPU grant once STARVE_MAX is reached.
// Only present when MEM_ARB_STARVE_GUARD_EN is defined; otherwise the
// arbiter uses strict external priority and this module does not exist.
`ifdef MEM_ARB_STARVE_GUARD_EN
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic arb_en_i,
  input  logic cpu_req_i,
  input  logic ext_req_i,
  output logic pick_ext_o
);

  logic [3:0] cnt_q, cnt_d;
  logic       force_cpu;

  assign force_cpu  = cpu_req_i && (cnt_q == 4'(STARVE_MAX));
  assign pick_ext_o = ext_req_i && !force_cpu;

  // Count external wins while the CPU waits; clear on a CPU win or when the CPU is not asking.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (arb_en_i) begin
      if (cpu_req_i && pick_ext_o) begin
        cnt_d = cnt_q + 4'd1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register updates together at the edge.
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Sequencer/arbiter for the single-ported cache memory shared by the CPU
// datapath and the external loader port. One access at a time: IDLE
// arbitrates, ACCESS drives the memory for one cycle, WAIT covers the read
// latency. External wins by default; defining MEM_ARB_STARVE_GUARD_EN adds
// a starvation guard that forces a CPU grant after STARVE_MAX external wins.
module mem_port_arbiter
  import riscmacro_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int MEM_LAT    = 0,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int                WAIT_W    = $clog2(MEM_LAT_MAX + 1);
  localparam bit                HAS_WAIT  = (MEM_LAT > MEM_LAT_MIN);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = HAS_WAIT ? WAIT_W'(MEM_LAT - 1) : '0;

  arb_state_e           state_q, state_d;
  req_id_t              id_q;
  logic                 we_q;
  logic [BIT_WIDTH-1:0] addr_q;
  logic [BIT_WIDTH-1:0] wdata_q;
  logic [WAIT_W-1:0]    wait_cnt_q;
  logic                 cpu_rvalid_q, ext_rvalid_q;
  logic [BIT_WIDTH-1:0] cpu_rdata_q, ext_rdata_q;

  logic arb_en;
  logic pick_ext;
  logic rd_done;

  assign arb_en  = (state_q == IDLE) && (bus.cpu_req || bus.ext_req);
  assign rd_done = ((state_q == ACCESS) && !we_q && !HAS_WAIT) ||
                   ((state_q == WAIT) && (wait_cnt_q == '0));

`ifdef MEM_ARB_STARVE_GUARD_EN
  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk        (clk),
    .reset      (reset),
    .arb_en_i   (arb_en),
    .cpu_req_i  (bus.cpu_req),
    .ext_req_i  (bus.ext_req),
    .pick_ext_o (pick_ext)
  );
`else
  assign pick_ext = bus.ext_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: arbitrate in IDLE, one access cycle, optional read-latency wait.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arb_en) state_d = ACCESS;
      ACCESS:  state_d = (!we_q && HAS_WAIT) ? WAIT : IDLE;
      WAIT:    if (wait_cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: grant pulse and write enable only during ACCESS.
  always_comb begin
    bus.cpu_gnt = 1'b0;
    bus.ext_gnt = 1'b0;
    bus.mem_we  = 1'b0;
    bus.busy    = (state_q != IDLE);
    if (state_q == ACCESS) begin
      bus.cpu_gnt = (id_q == REQ_CPU);
      bus.ext_gnt = (id_q == REQ_EXT);
      bus.mem_we  = we_q;
    end
  end

  // Latch the winner's request fields and ID at arbitration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q    <= REQ_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (arb_en) begin
      if (pick_ext) begin
        id_q    <= REQ_EXT;
        we_q    <= bus.ext_we;
        addr_q  <= bus.ext_addr;
        wdata_q <= bus.ext_wdata;
      end else begin
        id_q    <= REQ_CPU;
        we_q    <= bus.cpu_we;
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_wdata;
      end
    end
  end

  // Read-latency counter: load on the access cycle, count down in WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else if (state_q == ACCESS) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if ((state_q == WAIT) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
    end
  end

  // Register returned read data into the winner's port with a one-cycle valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
    end else begin
      cpu_rvalid_q <= rd_done && (id_q == REQ_CPU);
      ext_rvalid_q <= rd_done && (id_q == REQ_EXT);
      if (rd_done && (id_q == REQ_CPU)) cpu_rdata_q <= bus.mem_rdata;
      if (rd_done && (id_q == REQ_EXT)) ext_rdata_q <= bus.mem_rdata;
    end
  end

  // Address and write data come straight from the latched request, so they hold between accesses.
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ext_rvalid = ext_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with three instances (MEM_LAT 0, 2, 3)
// sharing clock and reset. Expected values are hand-derived from the cycle
// timing of the arbiter. Honours MEM_ARB_STARVE_GUARD_EN for the
// starvation scenario.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_vec;
  int   n_err;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.BIT_WIDTH(32)) if0 ();
  mem_port_arbiter_if #(.BIT_WIDTH(32)) if2 ();
  mem_port_arbiter_if #(.BIT_WIDTH(32)) if3 ();

  mem_port_arbiter #(.BIT_WIDTH(32), .MEM_LAT(0), .STARVE_MAX(4)) u_lat0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  mem_port_arbiter #(.BIT_WIDTH(32), .MEM_LAT(2), .STARVE_MAX(4)) u_lat2 (
    .clk(clk), .reset(reset), .bus(if2.slave));
  mem_port_arbiter #(.BIT_WIDTH(32), .MEM_LAT(3), .STARVE_MAX(4)) u_lat3 (
    .clk(clk), .reset(reset), .bus(if3.slave));

  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Zero-latency memory: write at the edge, combinational read.
  logic [31:0] mem0 [16];
  always @(posedge clk) if (if0.mem_we) mem0[if0.mem_addr[5:2]] <= if0.mem_wdata;
  assign if0.mem_rdata = mem0[if0.mem_addr[5:2]];

  // Latency-2 memory: data valid only in the cycle MEM_LAT after the access cycle.
  logic        fire2 [2];
  logic [31:0] pa2   [2];
  always @(posedge clk) begin
    fire2[0] <= (if2.cpu_gnt | if2.ext_gnt) & ~if2.mem_we;
    pa2[0]   <= if2.mem_addr;
    fire2[1] <= fire2[0];
    pa2[1]   <= pa2[0];
  end
  assign if2.mem_rdata = fire2[1] ? rd_pat(pa2[1]) : 32'hBAD0_BAD0;

  // Latency-3 memory.
  logic        fire3 [3];
  logic [31:0] pa3   [3];
  always @(posedge clk) begin
    fire3[0] <= (if3.cpu_gnt | if3.ext_gnt) & ~if3.mem_we;
    pa3[0]   <= if3.mem_addr;
    fire3[1] <= fire3[0];
    pa3[1]   <= pa3[0];
    fire3[2] <= fire3[1];
    pa3[2]   <= pa3[1];
  end
  assign if3.mem_rdata = fire3[2] ? rd_pat(pa3[2]) : 32'hBAD0_BAD0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.cpu_req = 0; if0.cpu_we = 0; if0.cpu_addr = '0; if0.cpu_wdata = '0;
    if0.ext_req = 0; if0.ext_we = 0; if0.ext_addr = '0; if0.ext_wdata = '0;
    if2.cpu_req = 0; if2.cpu_we = 0; if2.cpu_addr = '0; if2.cpu_wdata = '0;
    if2.ext_req = 0; if2.ext_we = 0; if2.ext_addr = '0; if2.ext_wdata = '0;
    if3.cpu_req = 0; if3.cpu_we = 0; if3.cpu_addr = '0; if3.cpu_wdata = '0;
    if3.ext_req = 0; if3.ext_we = 0; if3.ext_addr = '0; if3.ext_wdata = '0;
  endtask

  initial begin
    logic seen;
    int   busy_cnt;
    int   n_g;
    int   n_cg;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    clear_inputs();
    repeat (2) tick();

    // Reset state.
    check("rst0_ctl", {if0.busy, if0.cpu_gnt, if0.ext_gnt, if0.cpu_rvalid, if0.ext_rvalid, if0.mem_we}, '0);
    check("rst0_rdata", {if0.cpu_rdata, if0.ext_rdata}, '0);
    check("rst0_mem", {if0.mem_addr, if0.mem_wdata}, '0);
    check("rst2_ctl", {if2.busy, if2.cpu_gnt, if2.ext_gnt, if2.cpu_rvalid, if2.ext_rvalid, if2.mem_we}, '0);
    check("rst3_ctl", {if3.busy, if3.cpu_gnt, if3.ext_gnt, if3.cpu_rvalid, if3.ext_rvalid, if3.mem_we}, '0);
    reset = 1'b1;
    tick();

    // CPU write 0x10 <- DEADBEEF, then read back with MEM_LAT=0.
    if0.cpu_req = 1; if0.cpu_we = 1; if0.cpu_addr = 32'h10; if0.cpu_wdata = 32'hDEAD_BEEF;
    tick();
    check("wr_gnt", {if0.cpu_gnt, if0.ext_gnt, if0.busy, if0.mem_we}, 4'b1011);
    check("wr_bus", {if0.mem_addr, if0.mem_wdata}, {32'h10, 32'hDEAD_BEEF});
    if0.cpu_req = 0; if0.cpu_we = 0; if0.cpu_addr = '0; if0.cpu_wdata = '0;
    tick();
    check("wr_done", {if0.cpu_gnt, if0.busy, if0.mem_we, if0.cpu_rvalid}, 4'b0000);
    check("wr_addr_hold", if0.mem_addr, 32'h10);
    if0.cpu_req = 1; if0.cpu_addr = 32'h10;
    tick();
    check("rd0_gnt", {if0.cpu_gnt, if0.busy, if0.mem_we, if0.cpu_rvalid}, 4'b1100);
    if0.cpu_req = 0; if0.cpu_addr = '0;
    tick();
    check("rd0_rvalid", {if0.cpu_rvalid, if0.ext_rvalid, if0.busy}, 3'b100);
    check("rd0_rdata", if0.cpu_rdata, 32'hDEAD_BEEF);
    tick();
    check("rd0_pulse", if0.cpu_rvalid, 1'b0);
    check("rd0_hold", if0.cpu_rdata, 32'hDEAD_BEEF);

    // Simultaneous reads on MEM_LAT=2: ext to 0x8 first, then cpu to 0x4.
    if2.cpu_req = 1; if2.cpu_addr = 32'h4;
    if2.ext_req = 1; if2.ext_addr = 32'h8;
    tick();
    check("sim_first", {if2.ext_gnt, if2.cpu_gnt, if2.busy}, 3'b101);
    check("sim_first_addr", if2.mem_addr, 32'h8);
    if2.ext_req = 0; if2.ext_addr = '0;
    tick();
    tick();
    check("sim_wait", {if2.ext_gnt, if2.cpu_gnt, if2.busy, if2.ext_rvalid}, 4'b0010);
    tick();
    check("sim_ext_rv", {if2.ext_rvalid, if2.cpu_rvalid, if2.cpu_gnt, if2.busy}, 4'b1000);
    check("sim_ext_rdata", if2.ext_rdata, rd_pat(32'h8));
    tick();
    check("sim_second", {if2.cpu_gnt, if2.ext_gnt, if2.ext_rvalid}, 3'b100);
    check("sim_second_addr", if2.mem_addr, 32'h4);
    if2.cpu_req = 0; if2.cpu_addr = '0;
    repeat (3) tick();
    check("sim_cpu_rv", {if2.cpu_rvalid, if2.ext_rvalid}, 2'b10);
    check("sim_cpu_rdata", if2.cpu_rdata, rd_pat(32'h4));
    check("sim_ext_hold", if2.ext_rdata, rd_pat(32'h8));
    tick();

    // Reset asserted while a MEM_LAT=2 read sits in WAIT.
    if2.cpu_req = 1; if2.cpu_addr = 32'hC;
    tick();
    if2.cpu_req = 0; if2.cpu_addr = '0;
    tick();
    check("rstmid_inwait", {if2.busy, if2.cpu_gnt}, 2'b10);
    reset = 1'b0;
    #1;
    check("rstmid_ctl", {if2.busy, if2.cpu_gnt, if2.ext_gnt, if2.cpu_rvalid, if2.ext_rvalid, if2.mem_we}, '0);
    check("rstmid_data", {if2.cpu_rdata, if2.mem_addr}, '0);
    repeat (2) tick();
    reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | if2.cpu_rvalid | if2.busy | if2.mem_we;
    end
    check("rstmid_quiet", seen, 1'b0);

    // MEM_LAT=3 external read of 0x20.
    if3.ext_req = 1; if3.ext_addr = 32'h20;
    busy_cnt = 0;
    seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin
        check("lat3_gnt", if3.ext_gnt, 1'b1);
        if3.ext_req = 0; if3.ext_addr = '0;
      end
      if (if3.busy) busy_cnt++;
      seen = seen | if3.mem_we;
      check($sformatf("lat3_rv_c%0d", c), if3.ext_rvalid, (c == 5));
    end
    check("lat3_busy_cycles", busy_cnt, 4);
    check("lat3_no_we", seen, 1'b0);
    check("lat3_rdata", if3.ext_rdata, rd_pat(32'h20));

    // Both ports hold write requests continuously on MEM_LAT=0.
    if0.cpu_req = 1; if0.cpu_we = 1; if0.cpu_addr = 32'h30; if0.cpu_wdata = 32'h1111;
    if0.ext_req = 1; if0.ext_we = 1; if0.ext_addr = 32'h34; if0.ext_wdata = 32'h2222;
    n_g = 0;
    n_cg = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if0.cpu_gnt || if0.ext_gnt) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        check($sformatf("starve_pick%0d", n_g), if0.cpu_gnt, ((n_g % 5) == 4));
`else
        check($sformatf("strict_pick%0d", n_g), if0.cpu_gnt, 1'b0);
`endif
        n_g++;
        if (if0.cpu_gnt) n_cg++;
      end
    end
    check("held_grants", n_g, 10);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("starve_cpu_grants", n_cg, 2);
`else
    check("strict_cpu_grants", n_cg, 0);
`endif
    clear_inputs();
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
